scan_in: RTL and testbench
==========================

Name: scan_in

Overview:
- UART-receive-side console input block: collects characters from the UART RX byte stream and returns one result to the CPU over a four-phase req/ack handshake.
- Byte mode: the first received character is returned raw.
- Word mode: ASCII hex digits are parsed into a 32-bit word, terminated by CR or LF.
- Sits between the UART receiver and the CPU debug/IO unit; counterpart of the hex-print transmit path.

Parameters:
- MAX_DIGITS, 8, maximum hex digits kept in word mode; older digits shift out beyond this.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- d_rx  input  8  received character from UART RX
- vld_rx  input  1  d_rx valid; held until accepted
- rdy_rx  output  1  ready for a character; transfer when vld_rx && rdy_rx
- req_rx  input  1  CPU request; level, four-phase
- type_rx  input  1  0 = byte mode, 1 = hex word mode; sampled when the request is accepted
- din_rx  output  32  result to CPU; byte mode zero-extended
- ack_rx  output  1  result valid; four-phase acknowledge

Behaviour:
- Reset (synchronous, active-high, any state, including mid-parse): state=IDLE; rdy_rx=0, ack_rx=0, din_rx=0; accumulator=0; digit count=0; mode=0.
- All outputs are driven from registers or decoded from the state register only; no d_rx-to-output combinational path.
- IDLE:
  - req_rx=1 -> WAITRX; latch type_rx into mode; clear accumulator and count.
- WAITRX:
  - rdy_rx=1.
  - vld_rx=1 -> latch d_rx into a char register -> PARSE.
- PARSE (rdy_rx=0), byte mode:
  - din_rx <= {24'h0, char} -> ACK.
- PARSE, word mode:
  - hex digit (0-9, a-f, A-F): acc <= {acc[27:0], nibble}; count <= min(count+1, MAX_DIGITS) -> WAITRX.
  - '_' (0x5F): ignored (separator) -> WAITRX.
  - CR (0x0D) or LF (0x0A) with count>0: din_rx <= acc -> ACK.
  - CR or LF with count=0: ignored, so empty lines and CR-LF pairs do not complete -> WAITRX.
  - Any other character: ignored -> WAITRX.
- ACK:
  - ack_rx=1; din_rx held.
  - req_rx=0 -> IDLE; ack_rx falls in the same transition, low on the first cycle in IDLE.
  - While req_rx stays 1, remain in ACK.
- Four-phase rule: CPU keeps req_rx high until ack_rx=1, then drops it. A new request is only recognised in IDLE.
- din_rx keeps its last value until overwritten by the next completion or by reset.
- Latency: completing character accepted at cycle N -> ack_rx=1 at cycle N+2.
- More than 8 digits: leading digits are lost. Input "123456789\r" -> 0x23456789.
- req_rx dropped before ack (protocol violation): the block still completes and then waits in ACK only while req_rx=1. Since req_rx is already 0, it passes through ACK for one cycle (one-cycle ack_rx pulse) and returns to IDLE.
- vld_rx while not in WAITRX: not accepted; the UART receiver holds it.

Optional Feature:
- Macro SCAN_BS_EN.
- Defined: in word mode, backspace (0x08) or DEL (0x7F) removes the last digit: acc <= {4'h0, acc[31:4]}; count <= count-1 if count>0. With count=0 it is a no-op.
- Undefined: 0x08 and 0x7F are treated as invalid characters and ignored.
- Byte mode is unaffected either way; these codes are returned raw.

Decomposition:
- Shared package:
  - state encoding (IDLE, WAITRX, PARSE, ACK);
  - character constants CH_CR=8'h0D, CH_LF=8'h0A, CH_SEP=8'h5F, CH_BS=8'h08, CH_DEL=8'h7F;
  - mode constants MODE_BYTE=0, MODE_WORD=1.
- Sub-module char2hex: combinational ASCII-to-nibble decoder with outputs nibble[3:0] and is_hex. It is the inverse of the transmit-side hex-to-char converter and is shared by both paths.

Test Plan:
1. Byte mode: req_rx=1, type_rx=0; send 'A' (0x41) -> ack_rx=1 two cycles after the transfer, din_rx=0x00000041; drop req_rx -> ack_rx=0 next cycle, state IDLE.
2. Word mode: send "dead_BEEF\r" -> din_rx=0xDEADBEEF. A leading "\r\n" before the digits completes nothing.
3. Overflow and junk: send "12345678g9\n" -> 'g' ignored, din_rx=0x23456789.
4. Hold/handshake: keep req_rx=1 for 10 cycles after ack -> ack_rx stays 1 and din_rx is stable; a vld_rx character presented meanwhile is not accepted (rdy_rx=0).
5. Reset mid-parse: after "ab", assert rst for 1 cycle -> outputs zero, state IDLE; a new request with "7\r" yields din_rx=0x00000007, not 0xAB7.
6. SCAN_BS_EN: "12\x083\r" -> 0x13 when defined, 0x123 when undefined; backspace with count=0 followed by "5\r" -> 0x5.

Source files
------------

// File: rtl/scan_in_pkg.sv
// Shared definitions for the console receive path: FSM states, control characters, modes.
package scan_in_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITRX = 2'd1,
        PARSE  = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_SEP = 8'h5F;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;

    localparam logic MODE_BYTE = 1'b0;
    localparam logic MODE_WORD = 1'b1;

endpackage

// File: rtl/scan_in_char2hex.sv
// ASCII-to-nibble decoder; inverse of the transmit-side hex-to-char converter.
module scan_in_char2hex (
    input  logic [7:0] c_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o
);

    always_comb begin
        nibble_o = 4'h0;
        is_hex_o = 1'b0;
        if (c_i >= 8'h30 && c_i <= 8'h39) begin
            nibble_o = c_i[3:0];
            is_hex_o = 1'b1;
        end else if ((c_i >= 8'h41 && c_i <= 8'h46) || (c_i >= 8'h61 && c_i <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
            nibble_o = c_i[3:0] + 4'd9;
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/scan_in.sv
// Console input: returns a raw byte or a CR/LF-terminated hex word to the CPU over req/ack.
// Optional macro SCAN_BS_EN enables backspace/DEL digit removal in word mode.
module scan_in
    import scan_in_pkg::*;
#(
    parameter int MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d_rx,
    input  logic        vld_rx,
    output logic        rdy_rx,
    input  logic        req_rx,
    input  logic        type_rx,
    output logic [31:0] din_rx,
    output logic        ack_rx
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [31:0] ACC_MASK = (MAX_DIGITS >= 8) ? 32'hFFFF_FFFF
                                                         : ((32'h1 << (4 * MAX_DIGITS)) - 32'h1);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [7:0]       char_q, char_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      din_q, din_d;

    logic [3:0] nibble;
    logic       is_hex;

    scan_in_char2hex u_char2hex (
        .c_i      (char_q),
        .nibble_o (nibble),
        .is_hex_o (is_hex)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        char_d  = char_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (req_rx) begin
                    state_d = WAITRX;
                    mode_d  = type_rx;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            WAITRX: begin
                if (vld_rx) begin
                    char_d  = d_rx;
                    state_d = PARSE;
                end
            end
            PARSE: begin
                state_d = WAITRX;
                case (mode_q)
                    MODE_BYTE: begin
                        din_d   = {24'h0, char_q};
                        state_d = ACK;
                    end
                    MODE_WORD: begin
                        if (is_hex) begin
                            acc_d = {acc_q[27:0], nibble} & ACC_MASK;
                            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                        end else if (char_q == CH_SEP) begin
                            state_d = WAITRX;
                        end else if (char_q == CH_CR || char_q == CH_LF) begin
                            // empty lines and the LF of a CR-LF pair must not complete
                            if (cnt_q != '0) begin
                                din_d   = acc_q;
                                state_d = ACK;
                            end
                        end else if (char_q == CH_BS || char_q == CH_DEL) begin
`ifdef SCAN_BS_EN
                            if (cnt_q != '0) begin
                                acc_d = {4'h0, acc_q[31:4]};
                                cnt_d = cnt_q - 1'b1;
                            end
`else
                            state_d = WAITRX;
`endif
                        end
                    end
                endcase
            end
            ACK: begin
                if (!req_rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_BYTE;
            char_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            char_q  <= char_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
        end
    end

    assign rdy_rx = (state_q == WAITRX);
    assign ack_rx = (state_q == ACK);
    assign din_rx = din_q;

endmodule

// File: tb/tb_scan_in.sv
// Scoreboard bench for scan_in with a digit-list reference model; honours SCAN_BS_EN.
module tb_scan_in;

    localparam int MAX_DIGITS = 8;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d_rx;
    logic        vld_rx;
    logic        rdy_rx;
    logic        req_rx;
    logic        type_rx;
    logic [31:0] din_rx;
    logic        ack_rx;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] exp_q[$];
    logic [3:0]  mdl_dig[$];

    scan_in #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .d_rx    (d_rx),
        .vld_rx  (vld_rx),
        .rdy_rx  (rdy_rx),
        .req_rx  (req_rx),
        .type_rx (type_rx),
        .din_rx  (din_rx),
        .ack_rx  (ack_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: the word is the last MAX_DIGITS hex digits typed, read as a number.
    task automatic mdl_word_step(input logic [7:0] c, output bit done, output logic [31:0] val);
        int v;
        done = 1'b0;
        val  = '0;
        v    = -1;
        if (c >= "0" && c <= "9") v = int'(c) - int'("0");
        else if (c >= "a" && c <= "f") v = int'(c) - int'("a") + 10;
        else if (c >= "A" && c <= "F") v = int'(c) - int'("A") + 10;
        if (v >= 0) begin
            if (mdl_dig.size() == MAX_DIGITS) void'(mdl_dig.pop_front());
            mdl_dig.push_back(4'(v));
        end else if ((c == 8'h0D || c == 8'h0A) && mdl_dig.size() > 0) begin
            done = 1'b1;
            foreach (mdl_dig[i]) val = (val << 4) | 32'(mdl_dig[i]);
        end
`ifdef SCAN_BS_EN
        else if ((c == 8'h08 || c == 8'h7F) && mdl_dig.size() > 0) begin
            void'(mdl_dig.pop_back());
        end
`endif
    endtask

    task automatic send_char(input logic [7:0] c, output bit ok);
        ok     = 1'b0;
        vld_rx = 1'b1;
        d_rx   = c;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy_rx) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("rdy_timeout", 32'(rdy_rx), 32'd1);
            vld_rx = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        vld_rx = 1'b0;
    endtask

    // One full four-phase transaction; stops sending once the model says it completed.
    task automatic run_request(input bit mode, input bq_t chars, input int hold, input bit probe);
        bit          ok;
        bit          done;
        logic [31:0] val;
        done = 1'b0;
        val  = '0;
        mdl_dig.delete();
        type_rx = mode;
        req_rx  = 1'b1;
        foreach (chars[i]) begin
            send_char(chars[i], ok);
            if (!ok) break;
            if (mode == 1'b0) begin
                done = 1'b1;
                val  = {24'h0, chars[i]};
            end else begin
                mdl_word_step(chars[i], done, val);
            end
            if (done) begin
                exp_q.push_back(val);
                break;
            end
        end
        if (done) begin
            @(negedge clk);
            check("lat_early", 32'(ack_rx), 32'd0);
            @(negedge clk);
            check("lat_ack", 32'(ack_rx), 32'd1);
            for (int h = 0; h < hold; h++) begin
                if (probe) begin
                    vld_rx = 1'b1;
                    d_rx   = 8'($urandom);
                end
                @(negedge clk);
                check("hold_ack", 32'(ack_rx), 32'd1);
                check("hold_rdy", 32'(rdy_rx), 32'd0);
            end
        end
        vld_rx = 1'b0;
        req_rx = 1'b0;
        @(negedge clk);
        check("ack_fall", 32'(ack_rx), 32'd0);
        if (done) check("din_persist", din_rx, val);
    endtask

    // Monitor: compares each new acknowledge against the scoreboard.
    initial begin
        logic        ack_prev;
        logic [31:0] held;
        ack_prev = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (!rst && ack_rx && !ack_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack_rx), 32'd0);
                end else begin
                    held = exp_q.pop_front();
                    check("din", din_rx, held);
                end
            end else if (!rst && ack_rx && ack_prev) begin
                check("din_hold", din_rx, held);
            end
            ack_prev = ack_rx;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t   q;
        bit    ok;
        string hx;
        hx      = "0123456789abcdefABCDEF";
        rst     = 1'b1;
        req_rx  = 1'b0;
        vld_rx  = 1'b0;
        d_rx    = 8'h00;
        type_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", 32'(rdy_rx), 32'd0);
        check("rst_ack", 32'(ack_rx), 32'd0);
        check("rst_din", din_rx, 32'd0);

        // byte mode
        q = '{8'h41};
        run_request(1'b0, q, 0, 1'b0);

        // word mode with leading empty line
        q = '{8'h0D, 8'h0A};
        q = {q, str2q("dead_BEEF"), 8'h0D};
        run_request(1'b1, q, 1, 1'b0);

        // overflow and junk
        q = {str2q("12345678g9"), 8'h0A};
        run_request(1'b1, q, 0, 1'b0);

        // long hold with a character offered during ACK
        q = {str2q("C0FFEE"), 8'h0D};
        run_request(1'b1, q, 10, 1'b1);

        // reset in the middle of a parse
        type_rx = 1'b1;
        req_rx  = 1'b1;
        send_char("a", ok);
        send_char("b", ok);
        rst    = 1'b1;
        req_rx = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rdy", 32'(rdy_rx), 32'd0);
        check("midrst_ack", 32'(ack_rx), 32'd0);
        check("midrst_din", din_rx, 32'd0);
        q = {str2q("7"), 8'h0D};
        run_request(1'b1, q, 0, 1'b0);

        // backspace / delete handling
        q = {str2q("12"), 8'h08, str2q("3"), 8'h0D};
        run_request(1'b1, q, 0, 1'b0);
        q = {8'h08, 8'h7F, str2q("5"), 8'h0D};
        run_request(1'b1, q, 0, 1'b0);
        q = '{8'h7F};
        run_request(1'b0, q, 0, 1'b0);

        // request dropped before ack: one-cycle pulse
        type_rx = 1'b0;
        req_rx  = 1'b1;
        @(posedge clk);
        #1;
        req_rx = 1'b0;
        exp_q.push_back(32'h0000005A);
        send_char(8'h5A, ok);
        @(negedge clk);
        check("viol_early", 32'(ack_rx), 32'd0);
        @(negedge clk);
        check("viol_pulse", 32'(ack_rx), 32'd1);
        @(negedge clk);
        check("viol_fall", 32'(ack_rx), 32'd0);

        // randomized transactions
        for (int t = 0; t < 24; t++) begin
            bit mode;
            int len;
            mode = 1'($urandom);
            q.delete();
            if (!mode) begin
                q.push_back(8'($urandom));
            end else begin
                len = $urandom_range(0, 14);
                for (int k = 0; k < len; k++) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4: q.push_back(hx[$urandom_range(0, 21)]);
                        5:             q.push_back(8'h5F);
                        6:             q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
                        7:             q.push_back($urandom_range(0, 1) ? 8'h08 : 8'h7F);
                        default:       q.push_back(8'($urandom));
                    endcase
                end
                q.push_back(hx[$urandom_range(0, 21)]);
                q.push_back(8'h0D);
            end
            run_request(mode, q, $urandom_range(0, 3), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
